// File: rtl/washer_ctrl_fsm_pkg.sv
// Shared definitions for the washer sequencer: Gray state codes (also decoded
// by the phase timer) and the actuator bit positions of the output decode.
package washer_ctrl_fsm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b000,
      ST_SUPPLY  = 3'b001,
      ST_WASH    = 3'b011,
      ST_WATER   = 3'b010,
      ST_DEWATER = 3'b110,
      ST_ALARM   = 3'b100
   } state_t;

   localparam int ACT_W      = 5;
   localparam int ACT_INLET  = 0;
   localparam int ACT_DRAIN  = 1;
   localparam int ACT_MOTOR  = 2;
   localparam int ACT_FAST   = 3;
   localparam int ACT_BUZZER = 4;

   // Moore actuator decode; the drain stays open during an abnormal alarm so a
   // partly filled drum empties while the buzzer sounds.
   function automatic logic [ACT_W-1:0] decode_actuators(input state_t st, input logic fault);
      logic [ACT_W-1:0] v;
      v = '0;
      case (st)
         ST_SUPPLY:  v[ACT_INLET] = 1'b1;
         ST_WASH:    v[ACT_MOTOR] = 1'b1;
         ST_WATER:   v[ACT_DRAIN] = 1'b1;
         ST_DEWATER: begin
            v[ACT_DRAIN] = 1'b1;
            v[ACT_FAST]  = 1'b1;
         end
         ST_ALARM: begin
            v[ACT_BUZZER] = 1'b1;
            v[ACT_DRAIN]  = fault;
         end
         default:    v = '0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/washer_supply_watchdog.sv
// Fill watchdog: counts cycles while enabled and flags the last allowed cycle.
// Clear wins over enable; the count saturates so it never wraps.
module washer_supply_watchdog #(
   parameter int TIMEOUT = 600
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_timeout
);

   localparam int            W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LAST)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_timeout = i_enable && (r_count == LAST);

endmodule

// File: rtl/washer_ctrl_fsm.sv
// Washing-machine sequencer: RINSE_CYCLES rounds of supply/wash/drain/spin, then
// a buzzer phase, with fill watchdog and abort. Outputs decode from state only.
module washer_ctrl_fsm #(
   parameter int RINSE_CYCLES   = 3,
   parameter int SUPPLY_TIMEOUT = 600
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       water_full,
   input  logic       wash_done,
   input  logic       water_done,
   input  logic       dewater_done,
   input  logic       alarm_done,
   output logic [2:0] state_out,
   output logic       inlet_valve,
   output logic       drain_valve,
   output logic       motor_on,
   output logic       motor_fast,
   output logic       buzzer,
   output logic       busy,
   output logic       fault,
   output logic [1:0] round_cnt,
   output logic       done
);

   import washer_ctrl_fsm_pkg::*;

   localparam logic [1:0] LAST_ROUND = 2'(RINSE_CYCLES - 1);

   state_t           r_state;
   logic             r_first;
   logic [1:0]       r_round;
   logic             r_fault;
   logic             r_done;

   state_t           w_state_nxt;
   logic [1:0]       w_round_nxt;
   logic             w_fault_nxt;
   logic             w_done_nxt;
   logic             w_timeout;
   logic             w_abort;
   logic [ACT_W-1:0] w_act;

   washer_supply_watchdog #(
      .TIMEOUT (SUPPLY_TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (r_state != ST_SUPPLY),
      .i_enable  (r_state == ST_SUPPLY),
      .o_timeout (w_timeout)
   );

   assign w_abort = abort && ((r_state == ST_SUPPLY) || (r_state == ST_WASH) ||
                              (r_state == ST_WATER)  || (r_state == ST_DEWATER));

   // Timer flags lag state_out by a cycle and stay high across states, so a
   // flag is honoured only after the first cycle and only for its own state.
   always_comb begin
      w_state_nxt = r_state;
      w_round_nxt = r_round;
      w_fault_nxt = r_fault;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_SUPPLY;
               w_round_nxt = 2'd0;
               w_fault_nxt = 1'b0;
            end
         end
         ST_SUPPLY: begin
            if (water_full) begin
               w_state_nxt = ST_WASH;
            end else if (w_timeout) begin
               w_state_nxt = ST_ALARM;
               w_fault_nxt = 1'b1;
            end
         end
         ST_WASH: begin
            if (!r_first && wash_done) w_state_nxt = ST_WATER;
         end
         ST_WATER: begin
            if (!r_first && water_done) w_state_nxt = ST_DEWATER;
         end
         ST_DEWATER: begin
            if (!r_first && dewater_done) begin
               if (r_round == LAST_ROUND) begin
                  w_state_nxt = ST_ALARM;
               end else begin
                  w_state_nxt = ST_SUPPLY;
                  w_round_nxt = r_round + 2'd1;
               end
            end
         end
         ST_ALARM: begin
            if (!r_first && alarm_done) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = !r_fault;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      if (w_abort) begin
         w_state_nxt = ST_ALARM;
         w_round_nxt = r_round;
         w_fault_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_first <= 1'b1;
         r_round <= 2'd0;
         r_fault <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_first <= (w_state_nxt != r_state);
         r_round <= w_round_nxt;
         r_fault <= w_fault_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // done is registered, so it pulses in the first IDLE cycle after ALARM.
   assign w_act       = decode_actuators(r_state, r_fault);
   assign state_out   = r_state;
   assign inlet_valve = w_act[ACT_INLET];
   assign drain_valve = w_act[ACT_DRAIN];
   assign motor_on    = w_act[ACT_MOTOR];
   assign motor_fast  = w_act[ACT_FAST];
   assign buzzer      = w_act[ACT_BUZZER];
   assign busy        = (r_state != ST_IDLE);
   assign fault       = r_fault;
   assign round_cnt   = r_round;
   assign done        = r_done;

endmodule

// File: tb/tb_washer_ctrl_fsm.sv
// Directed bench for washer_ctrl_fsm with a behavioural phase timer that can be
// swapped for hand-driven flags per scenario.
module tb_washer_ctrl_fsm;

   localparam logic [2:0] S_IDLE    = 3'b000;
   localparam logic [2:0] S_SUPPLY  = 3'b001;
   localparam logic [2:0] S_WASH    = 3'b011;
   localparam logic [2:0] S_WATER   = 3'b010;
   localparam logic [2:0] S_DEWATER = 3'b110;
   localparam logic [2:0] S_ALARM   = 3'b100;

   logic       clk = 1'b0;
   logic       reset, start, abort;
   logic       water_full, wash_done, water_done, dewater_done, alarm_done;
   logic [2:0] state_out;
   logic       inlet_valve, drain_valve, motor_on, motor_fast, buzzer;
   logic       busy, fault, done;
   logic [1:0] round_cnt;

   logic auto_mode;
   logic man_full, man_wash, man_water, man_dew, man_alarm;
   logic m_full, m_wash, m_water, m_dew, m_alarm;
   logic [2:0] t_prev;
   logic [4:0] t_cnt;

   int checks   = 0;
   int failures = 0;

   washer_ctrl_fsm #(
      .RINSE_CYCLES   (2),
      .SUPPLY_TIMEOUT (20)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .abort        (abort),
      .water_full   (water_full),
      .wash_done    (wash_done),
      .water_done   (water_done),
      .dewater_done (dewater_done),
      .alarm_done   (alarm_done),
      .state_out    (state_out),
      .inlet_valve  (inlet_valve),
      .drain_valve  (drain_valve),
      .motor_on     (motor_on),
      .motor_fast   (motor_fast),
      .buzzer       (buzzer),
      .busy         (busy),
      .fault        (fault),
      .round_cnt    (round_cnt),
      .done         (done)
   );

   always #5 clk = ~clk;

   assign water_full   = auto_mode ? m_full  : man_full;
   assign wash_done    = auto_mode ? m_wash  : man_wash;
   assign water_done   = auto_mode ? m_water : man_water;
   assign dewater_done = auto_mode ? m_dew   : man_dew;
   assign alarm_done   = auto_mode ? m_alarm : man_alarm;

   // Timer model: flag for a state rises ~5 cycles after entry and stays high
   // until the timer sees IDLE or SUPPLY; the drum reports full 3 cycles in.
   always @(posedge clk) begin
      if (reset) begin
         t_prev  <= S_IDLE;
         t_cnt   <= 5'd0;
         m_full  <= 1'b0;
         m_wash  <= 1'b0;
         m_water <= 1'b0;
         m_dew   <= 1'b0;
         m_alarm <= 1'b0;
      end else begin
         t_prev <= state_out;
         if (state_out != t_prev) t_cnt <= 5'd1;
         else if (t_cnt != 5'd31) t_cnt <= t_cnt + 5'd1;
         m_full <= (state_out == S_SUPPLY) && (state_out == t_prev) && (t_cnt >= 5'd2);
         if (state_out == S_IDLE || state_out == S_SUPPLY) begin
            m_wash  <= 1'b0;
            m_water <= 1'b0;
            m_dew   <= 1'b0;
            m_alarm <= 1'b0;
         end else if (state_out == t_prev && t_cnt == 5'd4) begin
            case (state_out)
               S_WASH:    m_wash  <= 1'b1;
               S_WATER:   m_water <= 1'b1;
               S_DEWATER: m_dew   <= 1'b1;
               S_ALARM:   m_alarm <= 1'b1;
               default:   ;
            endcase
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "global timeout");
   end

   task automatic clear_inputs();
      start = 0; abort = 0; man_full = 0; man_wash = 0;
      man_water = 0; man_dew = 0; man_alarm = 0;
   endtask

   task automatic apply_reset(input logic use_auto);
      @(negedge clk);
      clear_inputs();
      auto_mode = use_auto;
      reset = 1;
      repeat (2) @(negedge clk);
      reset = 0;
   endtask

   // Leaves the bench at the negedge of the first SUPPLY cycle.
   task automatic pulse_start();
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_state(input logic [2:0] st, input logic [1:0] rnd, input string name);
      int n;
      n = 0;
      while (!(state_out === st && round_cnt === rnd) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 300) begin
         failures++;
         $display("FAIL %s: state %b round %0d not reached, at %b/%0d", name, st, rnd, state_out, round_cnt);
      end
   endtask

   task automatic test_reset();
      apply_reset(1'b0);
      checks++;
      if ({state_out, inlet_valve, drain_valve, motor_on, motor_fast, buzzer, busy, fault, round_cnt, done} !== 13'b0) begin
         failures++;
         $display("FAIL reset_outputs: got state=%b in=%b dr=%b mo=%b mf=%b bz=%b busy=%b f=%b rc=%0d d=%b, want all 0",
                  state_out, inlet_valve, drain_valve, motor_on, motor_fast, buzzer, busy, fault, round_cnt, done);
      end
      abort = 1;
      repeat (2) @(negedge clk);
      abort = 0;
      checks++;
      if (state_out !== S_IDLE || fault !== 1'b0) begin
         failures++;
         $display("FAIL idle_abort_ignored: state=%b fault=%b, want 000/0", state_out, fault);
      end
   endtask

   task automatic test_normal_program();
      logic [2:0] exp_seq [10];
      logic [2:0] last;
      int idx, done_cnt;
      exp_seq = '{S_SUPPLY, S_WASH, S_WATER, S_DEWATER, S_SUPPLY,
                  S_WASH, S_WATER, S_DEWATER, S_ALARM, S_IDLE};
      apply_reset(1'b1);
      last = S_IDLE; idx = 0; done_cnt = 0;
      start = 1;
      for (int cyc = 0; cyc < 400 && idx < 10; cyc++) begin
         @(negedge clk);
         start = 0;
         if (done === 1'b1) done_cnt++;
         if (state_out !== last) begin
            checks++;
            if (state_out !== exp_seq[idx]) begin
               failures++;
               $display("FAIL seq_step%0d: state=%b, want %b", idx, state_out, exp_seq[idx]);
            end
            if (idx == 0 || idx == 1 || idx == 5 || idx == 7) begin
               checks++;
               if (round_cnt !== ((idx < 4) ? 2'd0 : 2'd1)) begin
                  failures++;
                  $display("FAIL seq_round%0d: round_cnt=%0d, want %0d", idx, round_cnt, (idx < 4) ? 0 : 1);
               end
            end
            if (idx == 7) begin
               checks++;
               if ({drain_valve, motor_fast, motor_on, inlet_valve} !== 4'b1100) begin
                  failures++;
                  $display("FAIL dewater_outputs: dr/mf/mo/in=%b%b%b%b, want 1100", drain_valve, motor_fast, motor_on, inlet_valve);
               end
            end
            if (idx == 9) begin
               checks++;
               if (done !== 1'b1) begin
                  failures++;
                  $display("FAIL done_on_idle: done=%b, want 1", done);
               end
            end
            last = state_out;
            idx++;
         end
      end
      checks++;
      if (idx != 10) begin
         failures++;
         $display("FAIL normal_timeout: reached step %0d, want 10", idx);
      end
      repeat (4) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
      end
      checks++;
      if (done_cnt != 1 || fault !== 1'b0) begin
         failures++;
         $display("FAIL done_once: done cycles=%0d fault=%b, want 1/0", done_cnt, fault);
      end
   endtask

   task automatic test_supply_timeout();
      int bad, done_cnt;
      apply_reset(1'b0);
      pulse_start();
      bad = 0;
      for (int k = 1; k < 20; k++) begin
         @(negedge clk);
         if (state_out !== S_SUPPLY) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL supply_hold: left SUPPLY early in %0d cycles, want 0", bad);
      end
      @(negedge clk);
      checks++;
      if ({state_out, fault, buzzer, drain_valve, inlet_valve} !== {S_ALARM, 4'b1110}) begin
         failures++;
         $display("FAIL timeout_alarm: state=%b f/bz/dr/in=%b%b%b%b, want 100 1110",
                  state_out, fault, buzzer, drain_valve, inlet_valve);
      end
      man_alarm = 1;
      @(negedge clk);
      checks++;
      if (state_out !== S_ALARM) begin
         failures++;
         $display("FAIL alarm_first_cycle_guard: state=%b, want 100", state_out);
      end
      done_cnt = 0;
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      checks++;
      if (state_out !== S_IDLE || fault !== 1'b1 || buzzer !== 1'b0 || drain_valve !== 1'b0) begin
         failures++;
         $display("FAIL fault_idle: state=%b fault=%b bz=%b dr=%b, want 000 1 0 0", state_out, fault, buzzer, drain_valve);
      end
      man_alarm = 0;
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
      end
      checks++;
      if (done_cnt != 0 || fault !== 1'b1) begin
         failures++;
         $display("FAIL fault_no_done: done cycles=%0d fault=%b, want 0/1", done_cnt, fault);
      end
      pulse_start();
      checks++;
      if (state_out !== S_SUPPLY || fault !== 1'b0) begin
         failures++;
         $display("FAIL fault_clear_on_start: state=%b fault=%b, want 001/0", state_out, fault);
      end
   endtask

   task automatic test_abort();
      int bad, done_cnt;
      apply_reset(1'b1);
      pulse_start();
      wait_state(S_DEWATER, 2'd0, "abort_reach_dewater");
      abort = 1;
      @(negedge clk);
      abort = 0;
      checks++;
      if ({state_out, fault, drain_valve, buzzer, motor_fast} !== {S_ALARM, 4'b1110}) begin
         failures++;
         $display("FAIL abort_to_alarm: state=%b f/dr/bz/mf=%b%b%b%b, want 100 1110",
                  state_out, fault, drain_valve, buzzer, motor_fast);
      end
      abort = 1;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (state_out !== S_ALARM || fault !== 1'b1) bad++;
      end
      abort = 0;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL abort_in_alarm: disturbed in %0d cycles, want 0", bad);
      end
      done_cnt = 0;
      for (int n = 0; n < 50 && state_out !== S_IDLE; n++) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
      end
      repeat (2) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
      end
      checks++;
      if (state_out !== S_IDLE || done_cnt != 0 || fault !== 1'b1) begin
         failures++;
         $display("FAIL abort_end: state=%b done cycles=%0d fault=%b, want 000/0/1", state_out, done_cnt, fault);
      end
   endtask

   task automatic test_wash_done_held();
      int bad;
      apply_reset(1'b0);
      pulse_start();
      man_full = 1;
      @(negedge clk);
      man_full = 0;
      man_wash = 1;
      checks++;
      if (state_out !== S_WASH || motor_on !== 1'b1) begin
         failures++;
         $display("FAIL wash_entry: state=%b motor_on=%b, want 011/1", state_out, motor_on);
      end
      @(negedge clk);
      checks++;
      if (state_out !== S_WASH) begin
         failures++;
         $display("FAIL wash_cycle2: state=%b, want 011", state_out);
      end
      @(negedge clk);
      checks++;
      if (state_out !== S_WATER || drain_valve !== 1'b1 || motor_on !== 1'b0) begin
         failures++;
         $display("FAIL wash_to_water: state=%b dr=%b mo=%b, want 010 1 0", state_out, drain_valve, motor_on);
      end
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         if (state_out !== S_WATER) bad++;
      end
      man_wash = 0;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL stale_wash_done: left WATER in %0d cycles, want 0", bad);
      end
   endtask

   task automatic test_start_ignored_and_reset();
      apply_reset(1'b1);
      pulse_start();
      wait_state(S_WASH, 2'd0, "reach_wash");
      start = 1;
      @(negedge clk);
      start = 0;
      checks++;
      if (state_out !== S_WASH || round_cnt !== 2'd0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL start_in_wash: state=%b round=%0d busy=%b, want 011/0/1", state_out, round_cnt, busy);
      end
      wait_state(S_WATER, 2'd1, "reach_water_r1");
      reset = 1;
      @(negedge clk);
      checks++;
      if ({state_out, inlet_valve, drain_valve, motor_on, motor_fast, buzzer, busy, fault, round_cnt, done} !== 13'b0) begin
         failures++;
         $display("FAIL midrun_reset: state=%b dr=%b busy=%b round=%0d, want all 0", state_out, drain_valve, busy, round_cnt);
      end
      reset = 0;
   endtask

   task automatic test_timeout_coincide();
      apply_reset(1'b0);
      pulse_start();
      for (int k = 1; k < 20; k++) @(negedge clk);
      man_full = 1;
      @(negedge clk);
      man_full = 0;
      checks++;
      if (state_out !== S_WASH || fault !== 1'b0) begin
         failures++;
         $display("FAIL full_and_timeout: state=%b fault=%b, want 011/0", state_out, fault);
      end
   endtask

   initial begin
      reset = 1;
      auto_mode = 0;
      clear_inputs();
      test_reset();
      test_normal_program();
      test_supply_timeout();
      test_abort();
      test_wash_done_held();
      test_start_ignored_and_reset();
      test_timeout_coincide();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
